// File: rtl/sel_rom_pkg.sv
// sel_rom_pkg: shared widths, table contents and lookup helper for the
// fixed four-word coefficient/pattern ROM.
package sel_rom_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 2 ** ADDR_W;

    localparam logic [DATA_W-1:0] ROM_WORD0 = 8'hA5;
    localparam logic [DATA_W-1:0] ROM_WORD1 = 8'h3C;
    localparam logic [DATA_W-1:0] ROM_WORD2 = 8'h0F;
    localparam logic [DATA_W-1:0] ROM_WORD3 = 8'hF0;

    // Every index of the ADDR_W-bit space is covered, so the table never
    // sees an out-of-range entry; the default only catches X/Z indices.
    function automatic logic [DATA_W-1:0] rom_lookup(input logic [ADDR_W-1:0] index);
        logic [DATA_W-1:0] word;
        case (index)
            2'd0:    word = ROM_WORD0;
            2'd1:    word = ROM_WORD1;
            2'd2:    word = ROM_WORD2;
            2'd3:    word = ROM_WORD3;
            default: word = '0;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/sel_rom_lut.sv
// sel_rom_lut: purely combinational address -> word table, reusable
// without the output register of sel_rom.
module sel_rom_lut #(
    parameter int DATA_W = sel_rom_pkg::DATA_W,
    parameter int ADDR_W = sel_rom_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] word
);

    import sel_rom_pkg::*;

    // Table lookup; the address is fitted to the table's index width so a
    // wider source keeps only its low bits.
    always_comb begin
        word = DATA_W'(rom_lookup(sel_rom_pkg::ADDR_W'(address)));
    end

endmodule

// File: rtl/sel_rom.sv
// sel_rom: fixed four-word lookup table with select gating and a
// registered output (one cycle latency) plus a matching valid flag.
module sel_rom #(
    parameter int DATA_W = sel_rom_pkg::DATA_W,
    parameter int ADDR_W = sel_rom_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic              sel,
    output logic [DATA_W-1:0] data,
    output logic              data_valid
);

    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] next_data;

    sel_rom_lut #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_lut (
        .address (address),
        .word    (word)
    );

    // Deselected reads produce zero, which also keeps an undriven address
    // from reaching the output while sel is low.
    always_comb begin
        next_data = '0;
        if (sel) begin
            next_data = word;
        end
    end

    // Output registers; reset clears them asynchronously and drops any
    // read that was in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data       <= '0;
            data_valid <= 1'b0;
        end else begin
            data       <= next_data;
            data_valid <= sel;
        end
    end

endmodule

// File: tb/tb_sel_rom.sv
// tb_sel_rom: directed and randomized checks of sel_rom against a
// table-based reference model.
module tb_sel_rom;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] address;
    logic       sel;
    logic [7:0] data;
    logic       data_valid;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [7:0] rom_ref [4] = '{8'hA5, 8'h3C, 8'h0F, 8'hF0};

    sel_rom #(
        .DATA_W (8),
        .ADDR_W (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .sel        (sel),
        .data       (data),
        .data_valid (data_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Reference: a source value of any width indexes the 4-entry table modulo 4.
    function automatic logic [7:0] ref_word(input int unsigned a, input bit s);
        return s ? rom_ref[a % 4] : 8'h00;
    endfunction

    task automatic step(input string tag, input int unsigned a, input bit s);
        @(negedge clk);
        address = 2'(a);
        sel     = s;
        @(posedge clk);
        #1;
        check({tag, "_data"},  data,                 ref_word(a, s));
        check({tag, "_valid"}, {7'b0, data_valid},   {7'b0, s});
    endtask

    // Async reset pulse between edges; outputs must clear immediately.
    task automatic rst_pulse(input string tag);
        #1 rst = 1'b1;
        #1;
        check({tag, "_rst_data"},  data,               8'h00);
        check({tag, "_rst_valid"}, {7'b0, data_valid}, 8'h00);
        #1 rst = 1'b0;
    endtask

    initial begin
        int unsigned ra;
        bit          rs;

        // Reset with a live read request pending.
        address = 2'd2;
        sel     = 1'b1;
        rst     = 1'b1;
        #1;
        check("reset_imm_data",  data,               8'h00);
        check("reset_imm_valid", {7'b0, data_valid}, 8'h00);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_hold_data",  data,               8'h00);
            check("reset_hold_valid", {7'b0, data_valid}, 8'h00);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_release_data",  data,               8'h0F);
        check("reset_release_valid", {7'b0, data_valid}, 8'h01);

        // Deselected.
        repeat (3) step("desel", 0, 1'b0);

        // Sequential sweep.
        for (int unsigned i = 0; i < 4; i++) step("sweep", i, 1'b1);

        // Wide source value 4 truncates to index 0.
        step("wrap", 4, 1'b1);
        step("wrap7", 7, 1'b1);

        // Select toggle on a fixed address.
        step("tog1", 3, 1'b1);
        step("tog0", 3, 1'b0);
        step("tog1b", 3, 1'b1);

        // Mid-stream reset during a sweep.
        step("mid_a", 0, 1'b1);
        step("mid_b", 1, 1'b1);
        @(negedge clk);
        address = 2'd2;
        sel     = 1'b1;
        rst_pulse("mid");
        @(posedge clk);
        #1;
        check("mid_after_data",  data,               8'h0F);
        check("mid_after_valid", {7'b0, data_valid}, 8'h01);
        step("mid_c", 3, 1'b1);

        // Randomized traffic with occasional async reset pulses.
        for (int unsigned i = 0; i < 300; i++) begin
            ra = $urandom_range(0, 7);
            rs = 1'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                @(negedge clk);
                address = 2'(ra);
                sel     = rs;
                rst_pulse("rnd");
                @(posedge clk);
                #1;
                check("rnd_post_rst_data",  data,               ref_word(ra, rs));
                check("rnd_post_rst_valid", {7'b0, data_valid}, {7'b0, rs});
            end else begin
                step("rnd", ra, rs);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sel_rom.md
# sel_rom

Small read-only lookup memory: four 8-bit constant words selected by a 2-bit address, gated by a select/enable input. Used as a fixed coefficient/pattern table feeding datapath logic. Output is registered, one cycle behind the sampled address, with a valid flag. When deselected, the output is forced to zero.

## Interface
Parameters:
- DATA_W, 8, word width in bits.
- ADDR_W, 2, address width; depth is 2**ADDR_W = 4 words.

Ports:
- Clocking is fixed: one clock; reset is asynchronous and active-high.
- clk  input  1  rising-edge clock; all state updates on this edge.
- rst  input  1  asynchronous, active-high reset.
- address  input  ADDR_W  word index; sampled on the rising clk edge.
- sel  input  1  read enable/select; sampled on the rising clk edge.
- data  output  DATA_W  registered read word; 0 when the sampled sel was 0.
- data_valid  output  1  registered copy of the sampled sel.

## Operation
- Contents are fixed constants, not writable:
  - word 0 = 8'hA5
  - word 1 = 8'h3C
  - word 2 = 8'h0F
  - word 3 = 8'hF0
- Read path:
  - Combinational lookup: word = ROM[address].
  - Output mux: next_data = sel ? word : 0.
  - Output register: data <= next_data; data_valid <= sel.
- Address is exactly ADDR_W bits. Any wider value driven by a source truncates to its low bits (e.g. 4 -> index 0). The ROM never sees an out-of-range index.
- X/Z on address while sel=0 must not propagate: data = 0.
- No state beyond the two output registers; no FSM.

## Timing
- Reset (async assert, any time):
  - data = 8'h00 and data_valid = 0 immediately, independent of clk.
  - Both hold while rst is high.
  - Reset mid-stream discards the pending read.
- Deassertion: first rising edge with rst low samples address/sel normally.
- Latency: exactly 1 cycle. Inputs present at edge N appear on data/data_valid after edge N; they remain stable until edge N+1.
- Throughput: one read per cycle; back-to-back address changes are all honoured.
- sel falling at edge N: data = 0 and data_valid = 0 after edge N. The previous word is not held.
- sel and address changing on the same edge: the new pair is used together.

## Structure
- Package sel_rom_pkg holds:
  - DATA_W and ADDR_W default constants.
  - The four content constants (ROM_WORD0..ROM_WORD3).
  - A function rom_lookup(index) returning the word for an index.
- Optional sub-module sel_rom_lut: purely combinational, address -> word, built on the package function. Keep it separate so the table can be reused without the output register.
- Top module sel_rom contains the sel gating mux and the two output flops with async reset.

## Test plan
- Reset: assert rst with address=2, sel=1 -> data=8'h00 and data_valid=0 immediately and throughout reset. After release and one edge -> data=8'h0F, data_valid=1.
- Deselected: sel=0, address=0 for several cycles -> data=8'h00, data_valid=0.
- Sequential sweep, sel=1, address 0,1,2,3 on consecutive edges -> data 8'hA5, 8'h3C, 8'h0F, 8'hF0, each one cycle after its address. data_valid=1 throughout.
- Wrap: drive a 3-bit value 4, truncated to 2'b00, with sel=1 -> data=8'hA5 on the next edge.
- Select toggle: address=3; sel pattern 1,0,1 -> data 8'hF0, 8'h00, 8'hF0; data_valid 1,0,1.
- Mid-stream reset: during the sweep, pulse rst asynchronously between edges -> data clears at once. On the first edge after release, data reflects the current address, with no stale word.
